// File: rtl/fifo_lane_err_monitor.sv
// Edge-counting event monitor for the FIFO test lane: saturating counters plus a
// prioritised, optionally time-stamped event stream (FIFO_LANE_ERR_MON_TIMESTAMP_EN).
module fifo_lane_err_monitor #(
   parameter int K  = 48,
   parameter int M  = 3,
   parameter int CW = 32,
   parameter int TW = 24,
   parameter int IW = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [K-1:0]     sbiterr_i,
   input  logic [K-1:0]     dbiterr_i,
   input  logic [M-1:0]     err_i,
   input  logic             pg_warn_i,
   input  logic             clr_i,
   output logic [CW-1:0]    sbit_cnt_o,
   output logic [CW-1:0]    dbit_cnt_o,
   output logic [CW-1:0]    err_cnt_o,
   output logic [CW-1:0]    pg_cnt_o,
   output logic [CW-1:0]    lost_cnt_o,
   output logic             evt_valid_o,
   input  logic             evt_ready_i,
   output logic [TW+IW-1:0] evt_data_o
);
   localparam int N  = 2*K + M + 1;
   localparam int PW = $clog2(N + 1);
   localparam int SW = ((CW > PW) ? CW : PW) + 1;
   localparam logic [CW-1:0] CMAX = '1;

   logic [N-1:0]  s_vec, prev_q, edg, pend_q, pend_d, clr_mask;
   logic [IW-1:0] sel;
   logic [TW-1:0] ts_q;
   logic          load_ok, load, lost_any;

   function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
      logic [PW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) c = c + PW'(v[i]);
      return c;
   endfunction

   // Sum is formed wide enough for both operands so a large popcount cannot alias.
   function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [PW-1:0] b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      return (s > SW'(CMAX)) ? CMAX : s[CW-1:0];
   endfunction

   assign s_vec = {pg_warn_i, err_i, dbiterr_i, sbiterr_i};
   assign edg   = (rst_i || clr_i) ? '0 : (s_vec & ~prev_q);

`ifdef FIFO_LANE_ERR_MON_TIMESTAMP_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) ts_q <= '0;
      else       ts_q <= ts_q + 1'b1;
   end
`else
   assign ts_q = '0;
`endif

   assign load_ok = !evt_valid_o || evt_ready_i;
   assign load    = load_ok && (|pend_q);

   always_comb begin
      sel = '0;
      for (int i = N-1; i >= 0; i--)
         if (pend_q[i]) sel = IW'(i);
   end

   assign clr_mask = load ? (N'(1) << sel) : '0;
   assign pend_d   = (pend_q & ~clr_mask) | edg;
   assign lost_any = |(edg & pend_q & ~clr_mask);

   always_ff @(posedge clk_i) begin
      prev_q <= s_vec;
      if (rst_i || clr_i) begin
         sbit_cnt_o  <= '0;
         dbit_cnt_o  <= '0;
         err_cnt_o   <= '0;
         pg_cnt_o    <= '0;
         lost_cnt_o  <= '0;
         pend_q      <= '0;
         evt_valid_o <= 1'b0;
         evt_data_o  <= '0;
      end else begin
         sbit_cnt_o <= sat_add(sbit_cnt_o, popcnt(N'(edg[K-1:0])));
         dbit_cnt_o <= sat_add(dbit_cnt_o, popcnt(N'(edg[2*K-1:K])));
         err_cnt_o  <= sat_add(err_cnt_o,  popcnt(N'(edg[2*K+M-1:2*K])));
         pg_cnt_o   <= sat_add(pg_cnt_o,   popcnt(N'(edg[N-1])));
         if (lost_any) lost_cnt_o <= sat_add(lost_cnt_o, PW'(1));
         pend_q <= pend_d;
         if (load) begin
            evt_valid_o <= 1'b1;
            evt_data_o  <= {ts_q, sel};
         end else if (load_ok) begin
            evt_valid_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fifo_lane_err_monitor.sv
// Scoreboard bench for fifo_lane_err_monitor: directed stimulus pushes expected
// records, a negedge monitor pops and compares on every handshake.
module tb_fifo_lane_err_monitor;
   logic        clk, rst, clr, pg, ready;
   logic [47:0] sbit, dbit;
   logic [2:0]  err;
   logic [31:0] sbit_cnt, dbit_cnt, err_cnt, pg_cnt, lost_cnt;
   logic        evt_valid;
   logic [31:0] evt_data;
   logic [3:0]  s_sbit, s_dbit, s_err, s_pg, s_lost;
   logic        s_valid;
   logic [31:0] s_data;
   logic [23:0] cyc;
   int checks = 0, failures = 0;

   typedef struct { logic [23:0] ts; logic [7:0] src; } rec_t;
   rec_t exp_q[$];
   rec_t e;

   fifo_lane_err_monitor u_dut (
      .clk_i(clk), .rst_i(rst), .sbiterr_i(sbit), .dbiterr_i(dbit), .err_i(err),
      .pg_warn_i(pg), .clr_i(clr), .sbit_cnt_o(sbit_cnt), .dbit_cnt_o(dbit_cnt),
      .err_cnt_o(err_cnt), .pg_cnt_o(pg_cnt), .lost_cnt_o(lost_cnt),
      .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_data_o(evt_data));

   fifo_lane_err_monitor #(.CW(4)) u_sat (
      .clk_i(clk), .rst_i(rst), .sbiterr_i(sbit), .dbiterr_i(dbit), .err_i(err),
      .pg_warn_i(pg), .clr_i(clr), .sbit_cnt_o(s_sbit), .dbit_cnt_o(s_dbit),
      .err_cnt_o(s_err), .pg_cnt_o(s_pg), .lost_cnt_o(s_lost),
      .evt_valid_o(s_valid), .evt_ready_i(1'b1), .evt_data_o(s_data));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Reference timestamp: cleared by reset only.
   always @(posedge clk) cyc <= rst ? 24'd0 : cyc + 24'd1;

   always @(negedge clk) begin
      if (!rst && evt_valid && ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_record got=%h", evt_data);
         end else begin
            e = exp_q.pop_front();
            if (evt_data !== {e.ts, e.src}) begin
               failures++;
               $display("FAIL record got=%h exp=%h", evt_data, {e.ts, e.src});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic push(input logic [23:0] t, input int s);
      rec_t r;
`ifdef FIFO_LANE_ERR_MON_TIMESTAMP_EN
      r.ts = t;
`else
      r.ts = 24'd0;
`endif
      r.src = 8'(s);
      exp_q.push_back(r);
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
      tick();
      chk(nm, exp_q.size(), 0);
   endtask

   task automatic do_clr();
      clr = 1; tick(); clr = 0;
   endtask

   logic [23:0] c;

   initial begin
      rst = 1; clr = 0; pg = 0; ready = 1; sbit = '0; dbit = '0; err = '0;
      repeat (3) tick();
      chk("rst_sbit", sbit_cnt, 0);
      chk("rst_dbit", dbit_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_pg", pg_cnt, 0);
      chk("rst_lost", lost_cnt, 0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_data", evt_data, 0);
      rst = 0; tick();

      // single pulse, 3 cycles high
      sbit[5] = 1; tick();
      push(cyc, 5);
      chk("lat_n_valid", evt_valid, 0);
      tick();
      chk("lat_n1_valid", evt_valid, 1);
      tick(); sbit[5] = 0;
      drain("drain_single");
      chk("single_sbit", sbit_cnt, 1);
      chk("single_lost", lost_cnt, 0);

      // simultaneous sources
      dbit[0] = 1; err[1] = 1; pg = 1; tick();
      c = cyc;
      push(c, 48); push(c + 24'd1, 97); push(c + 24'd2, 99);
      drain("drain_simul");
      chk("simul_dbit", dbit_cnt, 1);
      chk("simul_err", err_cnt, 1);
      chk("simul_pg", pg_cnt, 1);
      dbit[0] = 0; err[1] = 0; pg = 0; tick();

      // backpressure: blocker record held, then two pulses on sbiterr[2]
      do_clr();
      chk("clr_sbit", sbit_cnt, 0);
      ready = 0; err[0] = 1; tick();
      push(cyc, 96); tick();
      sbit[2] = 1; tick(); sbit[2] = 0; tick(); sbit[2] = 1; tick(); sbit[2] = 0; tick();
      chk("bp_sbit", sbit_cnt, 2);
      chk("bp_lost", lost_cnt, 1);
      chk("bp_err", err_cnt, 1);
      chk("bp_valid_held", evt_valid, 1);
      ready = 1; push(cyc, 2);
      drain("drain_bp");
      err[0] = 0; tick();

      // clear with pending events
      ready = 0; sbit[3:0] = 4'hf; tick(); tick();
      do_clr();
      chk("clr_sbit2", sbit_cnt, 0);
      chk("clr_lost", lost_cnt, 0);
      chk("clr_valid", evt_valid, 0);
      chk("clr_data", evt_data, 0);
      ready = 1; repeat (3) tick();
      chk("clr_no_evt", evt_valid, 0);
      sbit[3:0] = 4'h0; tick();

      // saturation on the CW=4 instance
      do_clr();
      chk("sat_pre", s_sbit, 0);
      sbit = '1; tick();
      c = cyc;
      for (int i = 0; i < 48; i++) push(c + 24'(i), i);
      chk("sat_first", s_sbit, 15);
      chk("full_sbit", sbit_cnt, 48);
      drain("drain_sat1");
      sbit = '0; tick();
      sbit = '1; tick();
      c = cyc;
      for (int i = 0; i < 48; i++) push(c + 24'(i), i);
      chk("sat_hold", s_sbit, 15);
      chk("full_sbit2", sbit_cnt, 96);
      drain("drain_sat2");
      chk("sat_lost", lost_cnt, 0);
      sbit = '0; tick();

      // reset mid-stream with a held record and levels held through reset
      ready = 0; err[2] = 1; tick(); tick();
      sbit[0] = 1; rst = 1; tick(); tick(); rst = 0;
      chk("mrst_valid", evt_valid, 0);
      chk("mrst_lost", lost_cnt, 0);
      repeat (5) tick();
      chk("mrst_valid2", evt_valid, 0);
      chk("mrst_sbit", sbit_cnt, 0);
      chk("mrst_err", err_cnt, 0);
      ready = 1; repeat (3) tick();
      sbit[0] = 0; err[2] = 0; tick();

      // single pulse again after reset: timestamp restarts from reset
      sbit[5] = 1; tick();
      push(cyc, 5);
      chk("lat2_n_valid", evt_valid, 0);
      tick();
      chk("lat2_n1_valid", evt_valid, 1);
      tick(); sbit[5] = 0;
      drain("drain_single2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
